// File: rtl/reg_universal_n.sv
//------------------------------------------------------------------------------
// reg_universal_n : WIDTH-bit universal register (load/shift/rotate/inc/dec) with
// registered carry-out and combinational zero flag.          Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module reg_universal_n #(
   parameter int                WIDTH       = 32,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             LOAD,
   input  logic [2:0]       MODE,
   input  logic [WIDTH-1:0] D,
   input  logic             SI,
   output logic [WIDTH-1:0] Q,
   output logic             CO,
   output logic             Z
);

   localparam logic [2:0] c_MODE_HOLD = 3'b000;
   localparam logic [2:0] c_MODE_LOAD = 3'b001;
   localparam logic [2:0] c_MODE_SLL  = 3'b010;
   localparam logic [2:0] c_MODE_SRL  = 3'b011;
   localparam logic [2:0] c_MODE_SRA  = 3'b100;
   localparam logic [2:0] c_MODE_ROL  = 3'b101;
   localparam logic [2:0] c_MODE_INC  = 3'b110;
   localparam logic [2:0] c_MODE_DEC  = 3'b111;

   localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_q;
   logic             r_co;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_co_nxt;

   // Shared ripple add/sub chain: SnA=1 forms Q + ~1 + 1 (i.e. Q - 1).
   logic             w_sna;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH:0]   w_c;

   assign w_sna  = (MODE == c_MODE_DEC);
   assign w_b    = c_ONE ^ {WIDTH{w_sna}};
   assign w_c[0] = w_sna;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
         assign w_sum[i]   = r_q[i] ^ w_b[i] ^ w_c[i];
         assign w_c[i+1]   = (r_q[i] & w_b[i]) | (w_c[i] & (r_q[i] ^ w_b[i]));
      end
   endgenerate

   always_comb begin
      w_q_nxt  = r_q;
      w_co_nxt = r_co;
      if (LOAD) begin
         case (MODE)
            c_MODE_HOLD: begin
               w_q_nxt  = r_q;
               w_co_nxt = r_co;
            end
            c_MODE_LOAD: begin
               w_q_nxt  = D;
               w_co_nxt = 1'b0;
            end
            c_MODE_SLL: begin
               w_q_nxt  = {r_q[WIDTH-2:0], SI};
               w_co_nxt = r_q[WIDTH-1];
            end
            c_MODE_SRL: begin
               w_q_nxt  = {SI, r_q[WIDTH-1:1]};
               w_co_nxt = r_q[0];
            end
            c_MODE_SRA: begin
               w_q_nxt  = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
               w_co_nxt = r_q[0];
            end
            c_MODE_ROL: begin
               w_q_nxt  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
               w_co_nxt = r_q[WIDTH-1];
            end
            c_MODE_INC: begin
               w_q_nxt  = w_sum;
               w_co_nxt = w_c[WIDTH];
            end
            c_MODE_DEC: begin
               // No carry out of the subtract chain means a borrow occurred.
               w_q_nxt  = w_sum;
               w_co_nxt = ~w_c[WIDTH];
            end
            default: begin
               w_q_nxt  = r_q;
               w_co_nxt = r_co;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_q  <= RESET_VALUE;
         r_co <= 1'b0;
      end else begin
         r_q  <= w_q_nxt;
         r_co <= w_co_nxt;
      end
   end

   assign Q  = r_q;
   assign CO = r_co;
   assign Z  = (r_q == '0);

endmodule

`default_nettype wire
